// File: rtl/pixel_shift_pkg.sv
// rtl/pixel_shift_pkg.sv - shared constants, channel state type and pixel-count helper
// Imported by the pixel shifter bank and its per-channel sub-module.
package pixel_shift_pkg;

  localparam int DEF_NUM_CH = 9;
  localparam int DEF_BPP    = 2;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_X_W    = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2
  } ch_state_t;

  function automatic int pix_per_word(input int word_w, input int bpp);
    return word_w / bpp;
  endfunction

endpackage

// File: rtl/pixel_shift_channel.sv
// rtl/pixel_shift_channel.sv - one double-buffered pixel shifter channel
// Shadow word is loaded during a line, committed at line start, then shifted out after an offset.
module pixel_shift_channel
  import pixel_shift_pkg::*;
#(
  parameter int BPP    = DEF_BPP,
  parameter int WORD_W = DEF_WORD_W,
  parameter int X_W    = DEF_X_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_flip,
  input  logic [X_W-1:0]    load_x,
  input  logic              commit,
  input  logic              pix_tick,
  output logic [BPP-1:0]    out_pix,
  output logic              out_active,
  output logic              idle
);

  localparam int PPW  = pix_per_word(WORD_W, BPP);
  localparam int PL_W = $clog2(PPW + 1);

  logic [WORD_W-1:0] sh_word_q;
  logic              sh_flip_q;
  logic [X_W-1:0]    sh_x_q;
  logic              sh_valid_q;

  logic [WORD_W-1:0] shift_q;
  logic              flip_q;
  logic [X_W-1:0]    wait_q;
  logic [PL_W-1:0]   pix_left_q;
  ch_state_t         state_q;
  logic [BPP-1:0]    out_pix_q;
  logic              out_active_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_word_q    <= '0;
      sh_flip_q    <= 1'b0;
      sh_x_q       <= '0;
      sh_valid_q   <= 1'b0;
      shift_q      <= '0;
      flip_q       <= 1'b0;
      wait_q       <= '0;
      pix_left_q   <= '0;
      state_q      <= IDLE;
      out_pix_q    <= '0;
      out_active_q <= 1'b0;
    end else begin
      if (load_en) begin
        sh_word_q <= load_data;
        sh_flip_q <= load_flip;
        sh_x_q    <= load_x;
      end
      // A simultaneous load refills the shadow while the commit consumes its old contents.
      if (commit) begin
        sh_valid_q <= load_en;
        if (sh_valid_q) begin
          shift_q    <= sh_word_q;
          flip_q     <= sh_flip_q;
          wait_q     <= sh_x_q;
          pix_left_q <= PL_W'(PPW);
          state_q    <= WAIT;
        end else begin
          state_q <= IDLE;
        end
        out_pix_q    <= '0;
        out_active_q <= 1'b0;
      end else begin
        if (load_en) sh_valid_q <= 1'b1;
        if (pix_tick) begin
          case (state_q)
            WAIT: begin
              if (wait_q != '0) begin
                wait_q       <= wait_q - X_W'(1);
                out_pix_q    <= '0;
                out_active_q <= 1'b0;
              end else begin
                out_pix_q    <= flip_q ? shift_q[WORD_W-1 -: BPP] : shift_q[BPP-1:0];
                shift_q      <= flip_q ? (shift_q << BPP) : (shift_q >> BPP);
                out_active_q <= 1'b1;
                pix_left_q   <= pix_left_q - PL_W'(1);
                state_q      <= SHIFT;
              end
            end
            SHIFT: begin
              if (pix_left_q != '0) begin
                out_pix_q    <= flip_q ? shift_q[WORD_W-1 -: BPP] : shift_q[BPP-1:0];
                shift_q      <= flip_q ? (shift_q << BPP) : (shift_q >> BPP);
                out_active_q <= 1'b1;
                pix_left_q   <= pix_left_q - PL_W'(1);
              end else begin
                out_pix_q    <= '0;
                out_active_q <= 1'b0;
                state_q      <= IDLE;
              end
            end
            default: begin
              out_pix_q    <= '0;
              out_active_q <= 1'b0;
              state_q      <= IDLE;
            end
          endcase
        end
      end
    end
  end

  assign out_pix    = out_pix_q;
  assign out_active = out_active_q;
  assign idle       = (state_q == IDLE);

endmodule

// File: rtl/pixel_shifter_bank.sv
// rtl/pixel_shifter_bank.sv - bank of per-channel pixel shifters for the line compositor
// Channel NUM_CH-1 is the background channel; the rest are sprite slots.
module pixel_shifter_bank
  import pixel_shift_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int BPP    = DEF_BPP,
  parameter int WORD_W = DEF_WORD_W,
  parameter int X_W    = DEF_X_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             load_en,
  input  logic [NUM_CH-1:0][WORD_W-1:0] load_data,
  input  logic [NUM_CH-1:0]             load_flip,
  input  logic [NUM_CH-1:0][X_W-1:0]    load_x,
  input  logic                          commit,
  input  logic                          pix_tick,
  output logic [NUM_CH-1:0][BPP-1:0]    out_pix,
  output logic [NUM_CH-1:0]             out_active,
  output logic                          all_idle
);

  logic [NUM_CH-1:0] ch_idle;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pixel_shift_channel #(
      .BPP    (BPP),
      .WORD_W (WORD_W),
      .X_W    (X_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .load_en    (load_en[g]),
      .load_data  (load_data[g]),
      .load_flip  (load_flip[g]),
      .load_x     (load_x[g]),
      .commit     (commit),
      .pix_tick   (pix_tick),
      .out_pix    (out_pix[g]),
      .out_active (out_active[g]),
      .idle       (ch_idle[g])
    );
  end

  assign all_idle = &ch_idle;

endmodule

// File: tb/tb_pixel_shifter_bank.sv
// tb/tb_pixel_shifter_bank.sv - randomized and directed bench against a pixel-index reference model
module tb_pixel_shifter_bank;

  localparam int NUM_CH = 9;
  localparam int BPP    = 2;
  localparam int WORD_W = 32;
  localparam int X_W    = 10;
  localparam int PPW    = WORD_W / BPP;

  logic                          clk = 1'b0;
  logic                          reset;
  logic [NUM_CH-1:0]             load_en;
  logic [NUM_CH-1:0][WORD_W-1:0] load_data;
  logic [NUM_CH-1:0]             load_flip;
  logic [NUM_CH-1:0][X_W-1:0]    load_x;
  logic                          commit;
  logic                          pix_tick;
  logic [NUM_CH-1:0][BPP-1:0]    out_pix;
  logic [NUM_CH-1:0]             out_active;
  logic                          all_idle;

  pixel_shifter_bank #(
    .NUM_CH (NUM_CH),
    .BPP    (BPP),
    .WORD_W (WORD_W),
    .X_W    (X_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .load_data  (load_data),
    .load_flip  (load_flip),
    .load_x     (load_x),
    .commit     (commit),
    .pix_tick   (pix_tick),
    .out_pix    (out_pix),
    .out_active (out_active),
    .all_idle   (all_idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a committed line is described by its word, flip, offset and the
  // number of ticks seen since commit; the output is derived from that tick index.
  logic [WORD_W-1:0] m_sh_word [NUM_CH];
  bit                m_sh_flip [NUM_CH];
  int                m_sh_x    [NUM_CH];
  bit                m_sh_v    [NUM_CH];
  logic [WORD_W-1:0] m_word    [NUM_CH];
  bit                m_flip    [NUM_CH];
  int                m_x       [NUM_CH];
  bit                m_line    [NUM_CH];
  int                m_k       [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_sh_word[c] = '0; m_sh_flip[c] = 0; m_sh_x[c] = 0; m_sh_v[c] = 0;
      m_word[c] = '0; m_flip[c] = 0; m_x[c] = 0; m_line[c] = 0; m_k[c] = 0;
    end
  endtask

  task automatic model_clock();
    for (int c = 0; c < NUM_CH; c++) begin
      if (commit) begin
        m_line[c] = m_sh_v[c];
        if (m_sh_v[c]) begin
          m_word[c] = m_sh_word[c]; m_flip[c] = m_sh_flip[c]; m_x[c] = m_sh_x[c]; m_k[c] = 0;
        end
        m_sh_v[c] = 0;
      end else if (pix_tick && m_line[c] && m_k[c] <= m_x[c] + PPW) begin
        m_k[c]++;
      end
      if (load_en[c]) begin
        m_sh_word[c] = load_data[c]; m_sh_flip[c] = load_flip[c];
        m_sh_x[c] = int'(load_x[c]); m_sh_v[c] = 1;
      end
    end
  endtask

  task automatic check_all();
    bit idle_exp = 1;
    for (int c = 0; c < NUM_CH; c++) begin
      bit act = 0;
      logic [31:0] pv = '0;
      if (m_line[c] && m_k[c] > m_x[c] && m_k[c] <= m_x[c] + PPW) begin
        int p = m_k[c] - m_x[c] - 1;
        int idx = m_flip[c] ? (PPW - 1 - p) : p;
        act = 1;
        pv = (m_word[c] >> (idx * BPP)) & ((32'd1 << BPP) - 1);
      end
      if (m_line[c] && m_k[c] <= m_x[c] + PPW) idle_exp = 0;
      chk($sformatf("pix_ch%0d", c), 32'(out_pix[c]), pv);
      chk($sformatf("act_ch%0d", c), 32'(out_active[c]), 32'(act));
    end
    chk("all_idle", 32'(all_idle), 32'(idle_exp));
  endtask

  task automatic step(input logic c, input logic t);
    @(negedge clk);
    commit = c;
    pix_tick = t;
    @(posedge clk);
    model_clock();
    #1;
    check_all();
    load_en = '0;
    commit = 1'b0;
    pix_tick = 1'b0;
  endtask

  task automatic set_load(input int c, input logic [WORD_W-1:0] w, input logic f, input int x);
    load_en[c] = 1'b1;
    load_data[c] = w;
    load_flip[c] = f;
    load_x[c] = X_W'(x);
  endtask

  initial begin
    reset = 1'b0; load_en = '0; load_data = '0; load_flip = '0; load_x = '0;
    commit = 1'b0; pix_tick = 1'b0;
    model_reset();
    #2;
    check_all();
    @(negedge clk); reset = 1'b1;

    // LSB-first word, zero offset, full line and return to idle
    set_load(0, 32'h0000_00E4, 1'b0, 0);
    step(0, 0);
    step(1, 0);
    for (int i = 0; i < 17; i++) begin
      step(0, 1);
      if (i < 4) chk("t1_pix", 32'(out_pix[0]), i);
      if (i == 16) chk("t1_end_act", 32'(out_active[0]), 0);
    end

    // MSB-first word with offset 2
    set_load(3, 32'hE400_0000, 1'b1, 2);
    step(0, 0);
    step(1, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1);
      if (i < 2) chk("t2_wait_act", 32'(out_active[3]), 0);
      else if (i < 6) chk("t2_pix", 32'(out_pix[3]), 5 - i);
    end

    // Commit mid-SHIFT aborts the old word and restarts from the new shadow
    set_load(1, 32'h5555_AAAA, 1'b0, 0);
    step(1, 0);
    step(1, 0);
    for (int i = 0; i < 5; i++) step(0, 1);
    set_load(1, 32'h1234_5678, 1'b1, 3);
    step(0, 1);
    step(1, 1);
    chk("t3_abort_act", 32'(out_active[1]), 0);
    for (int i = 0; i < 22; i++) step(0, 1);

    // Load colliding with commit on an invalid shadow: idle this line, runs next line
    set_load(2, 32'hCAFE_F00D, 1'b0, 1);
    step(1, 0);
    step(0, 1);
    chk("t4_idle_act", 32'(out_active[2]), 0);
    step(1, 0);
    for (int i = 0; i < 20; i++) step(0, 1);

    // Maximum offset counts down without underflow
    set_load(8, 32'h9876_5432, 1'b0, (1 << X_W) - 1);
    step(1, 0);
    step(1, 0);
    for (int i = 0; i < (1 << X_W) + PPW + 2; i++) step(0, 1);

    // Asynchronous reset mid-SHIFT on every channel
    for (int c = 0; c < NUM_CH; c++) set_load(c, $urandom, 1'($urandom), 0);
    step(1, 0);
    step(1, 0);
    for (int i = 0; i < 4; i++) step(0, 1);
    @(negedge clk); #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    step(1, 0);
    for (int i = 0; i < 3; i++) step(0, 1);

    // Random loads, ticks every third cycle, commits sometimes colliding with ticks
    for (int cyc = 0; cyc < 900; cyc++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          int xv = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, (1 << X_W) - 1))
                                                 : int'($urandom_range(0, 12));
          set_load(c, $urandom, 1'($urandom), xv);
        end
      end
      step(($urandom_range(0, 29) == 0) || (cyc % 45 == 0), (cyc % 3 == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
